// File: rtl/pht_2bit.sv
// 2-bit saturating-counter pattern history table with a post-reset/flush invalidation sweep.
// Optional perf counters are built when BPU_PERF_CNT_EN is defined; otherwise both counter ports read 0.
module pht_2bit #(
  parameter int unsigned INDEX_W = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  output logic        o_hit,
  output logic        o_pred_taken,
  output logic        o_ready,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic        i_upd_mispred,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int unsigned TAG_W = 30 - INDEX_W;
  localparam int unsigned DEPTH = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
  } entry_t;

  state_e             state_q;
  logic [INDEX_W-1:0] sweep_q;
  logic               ready_q;

  // Entry array carries no reset so it can map onto a RAM macro.
  entry_t mem_q [DEPTH];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  entry_t             lk_entry;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  entry_t             upd_entry;
  logic               upd_hit_c;
  logic               upd_accept_c;
  logic               wr_en_c;
  logic [INDEX_W-1:0] wr_idx_c;
  entry_t             wr_data_c;
  logic               unused_bits;

  assign lk_idx    = i_pc[INDEX_W+1:2];
  assign lk_tag    = i_pc[31:INDEX_W+2];
  assign lk_entry  = mem_q[lk_idx];
  assign upd_idx   = i_upd_pc[INDEX_W+1:2];
  assign upd_tag   = i_upd_pc[31:INDEX_W+2];
  assign upd_entry = mem_q[upd_idx];

  assign unused_bits = ^{i_pc[1:0], i_upd_pc[1:0], i_upd_mispred};

  // Lookup is combinational and sees the pre-update entry (no forwarding).
  assign o_hit        = ready_q & lk_entry.valid & (lk_entry.tag == lk_tag);
  assign o_pred_taken = o_hit & lk_entry.ctr[1];
  assign o_ready      = ready_q;

  assign upd_hit_c    = upd_entry.valid & (upd_entry.tag == upd_tag);
  assign upd_accept_c = (state_q == ST_READY) & i_upd_en & ~i_flush;

  // Sweep/FSM: flush has priority over everything and restarts from index 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else if (i_flush) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_q <= sweep_q + INDEX_W'(1);
          if (sweep_q == LAST_IDX) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Single write port shared by the sweep and the training path.
  always_comb begin
    wr_en_c         = 1'b0;
    wr_idx_c        = upd_idx;
    wr_data_c.valid = 1'b0;
    wr_data_c.tag   = '0;
    wr_data_c.ctr   = 2'b01;
    if (!i_flush) begin
      if (state_q == ST_INIT) begin
        wr_en_c  = 1'b1;
        wr_idx_c = sweep_q;
      end else if (upd_accept_c) begin
        wr_en_c         = 1'b1;
        wr_data_c.valid = 1'b1;
        wr_data_c.tag   = upd_tag;
        if (upd_hit_c) begin
          if (i_upd_taken) begin
            wr_data_c.ctr = (upd_entry.ctr == 2'b11) ? 2'b11 : upd_entry.ctr + 2'd1;
          end else begin
            wr_data_c.ctr = (upd_entry.ctr == 2'b00) ? 2'b00 : upd_entry.ctr - 2'd1;
          end
        end else begin
          wr_data_c.ctr = i_upd_taken ? 2'b10 : 2'b01;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= wr_data_c;
    end
  end

`ifdef BPU_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Saturating event counters; only reset clears them.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_accept_c) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (i_upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`else
  assign o_branch_cnt  = 32'd0;
  assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pht_2bit.sv
// Directed bench for pht_2bit: init sweep, training, aliasing, flush collisions, perf counters.
module tb_pht_2bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] pc;
  logic        hit;
  logic        pred;
  logic        ready;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispred;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 clk = ~clk;

  pht_2bit dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_pc         (pc),
    .o_hit        (hit),
    .o_pred_taken (pred),
    .o_ready      (ready),
    .i_upd_en     (upd_en),
    .i_upd_pc     (upd_pc),
    .i_upd_taken  (upd_taken),
    .i_upd_mispred(upd_mispred),
    .o_branch_cnt (br_cnt),
    .o_mispred_cnt(mp_cnt)
  );

  function automatic logic [31:0] perf_exp(input int v);
`ifdef BPU_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // One accepted update: driven on a negedge, sampled at the next posedge.
  task automatic upd(input logic [31:0] p, input logic tk, input logic mp);
    @(negedge clk);
    upd_en = 1'b1; upd_pc = p; upd_taken = tk; upd_mispred = mp;
    @(negedge clk);
    upd_en = 1'b0; upd_mispred = 1'b0;
    exp_br++;
    if (mp) exp_mp++;
  endtask

  task automatic test_reset;
    logic [31:0] pcs [6];
    pcs = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h8000_0ffc, 32'hffff_fffc, 32'h1234_5678};
    rst_n = 1'b0; flush = 1'b0; pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || hit !== 1'b0 || pred !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ready=%b hit=%b pred=%b, expected all 0", ready, hit, pred);
    end
    checks++;
    if (br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters: br=%0d mp=%0d, expected 0/0", br_cnt, mp_cnt);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 1024; n++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'(n == 1024)) begin
        errors++; $display("FAIL init_ready edge %0d: ready=%b, expected %b", n, ready, n == 1024);
      end
    end
    for (int i = 0; i < 6; i++) begin
      pc = pcs[i]; #1;
      checks++;
      if (hit !== 1'b0 || pred !== 1'b0) begin
        errors++; $display("FAIL init_miss pc=%h: hit=%b pred=%b, expected 0/0", pc, hit, pred);
      end
    end
  endtask

  task automatic test_perf;
    logic [31:0] pcs [5];
    logic        mps [5];
    pcs = '{32'h0000_4010, 32'h0000_4014, 32'h0000_4018, 32'h0000_401c, 32'h0000_4020};
    mps = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) upd(pcs[i], 1'b1, mps[i]);
    checks++;
    if (br_cnt !== perf_exp(5) || mp_cnt !== perf_exp(2)) begin
      errors++; $display("FAIL perf_counts: br=%0d mp=%0d, expected %0d/%0d", br_cnt, mp_cnt, perf_exp(5), perf_exp(2));
    end
  endtask

  task automatic test_allocation;
    upd(32'h0000_1000, 1'b1, 1'b0);
    pc = 32'h0000_1000; #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b1) begin
      errors++; $display("FAIL alloc_taken: hit=%b pred=%b, expected 1/1", hit, pred);
    end
    pc = 32'h0000_1003; #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b1) begin
      errors++; $display("FAIL alloc_low_bits_ignored: hit=%b pred=%b, expected 1/1", hit, pred);
    end
  endtask

  task automatic test_saturation;
    // ctr from 10: NT->01,00,00; T->01,10,11,11; NT->10,01
    logic dir [9];
    logic expp [9];
    dir  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    expp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      upd(32'h0000_1000, dir[i], 1'b0);
      pc = 32'h0000_1000; #1;
      checks++;
      if (hit !== 1'b1 || pred !== expp[i]) begin
        errors++; $display("FAIL saturation step %0d: hit=%b pred=%b, expected 1/%b", i, hit, pred, expp[i]);
      end
    end
  endtask

  task automatic test_aliasing;
    pc = 32'h0000_2000; #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL alias_lookup: hit=%b, expected 0", hit);
    end
    upd(32'h0000_2000, 1'b0, 1'b1);
    pc = 32'h0000_2000; #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b0) begin
      errors++; $display("FAIL alias_alloc: hit=%b pred=%b, expected 1/0", hit, pred);
    end
    pc = 32'h0000_1000; #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL alias_evicted: hit=%b, expected 0", hit);
    end
    pc = 32'h0000_1004; #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL other_index_miss: hit=%b, expected 0", hit);
    end
  endtask

  task automatic test_back_to_back;
    // 0x2000 at ctr 01; two taken updates on consecutive edges give 11
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 32'h0000_2000; upd_taken = 1'b1; upd_mispred = 1'b0;
    @(negedge clk);
    @(negedge clk);
    upd_en = 1'b0;
    exp_br += 2;
    upd(32'h0000_2000, 1'b0, 1'b0);
    pc = 32'h0000_2000; #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b1) begin
      errors++; $display("FAIL b2b_ctr10: hit=%b pred=%b, expected 1/1", hit, pred);
    end
    upd(32'h0000_2000, 1'b0, 1'b0);
    #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b0) begin
      errors++; $display("FAIL b2b_ctr01: hit=%b pred=%b, expected 1/0", hit, pred);
    end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    upd_en = 1'b1; upd_pc = 32'h0000_3008; upd_taken = 1'b1; upd_mispred = 1'b0;
    pc = 32'h0000_3008; #1;
    checks++;
    if (hit !== 1'b0 || pred !== 1'b0) begin
      errors++; $display("FAIL same_cycle_pre: hit=%b pred=%b, expected 0/0", hit, pred);
    end
    @(negedge clk);
    upd_en = 1'b0;
    exp_br++;
    #1;
    checks++;
    if (hit !== 1'b1 || pred !== 1'b1) begin
      errors++; $display("FAIL same_cycle_post: hit=%b pred=%b, expected 1/1", hit, pred);
    end
  endtask

  task automatic test_flush_mid_sweep;
    logic [31:0] pcs [4];
    pcs = '{32'h0000_2000, 32'h0000_3008, 32'h0000_4010, 32'h0000_7000};
    pc = 32'h0000_2000;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if (ready !== 1'b0 || hit !== 1'b0 || pred !== 1'b0) begin
      errors++; $display("FAIL flush_outputs: ready=%b hit=%b pred=%b, expected 0/0/0", ready, hit, pred);
    end
    for (int n = 1; n <= 500; n++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++; $display("FAIL sweep1_ready edge %0d: ready=%b, expected 0", n, ready);
      end
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int n = 1; n <= 1024; n++) begin
      if (n == 10) begin
        upd_en = 1'b1; upd_pc = 32'h0000_7000; upd_taken = 1'b1; upd_mispred = 1'b1;
      end else begin
        upd_en = 1'b0; upd_mispred = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'(n == 1024)) begin
        errors++; $display("FAIL sweep2_ready edge %0d: ready=%b, expected %b", n, ready, n == 1024);
      end
    end
    upd_en = 1'b0; upd_mispred = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = pcs[i]; #1;
      checks++;
      if (hit !== 1'b0) begin
        errors++; $display("FAIL post_sweep_miss pc=%h: hit=%b, expected 0", pc, hit);
      end
    end
    checks++;
    if (br_cnt !== perf_exp(exp_br) || mp_cnt !== perf_exp(exp_mp)) begin
      errors++; $display("FAIL init_update_counted: br=%0d mp=%0d, expected %0d/%0d", br_cnt, mp_cnt, perf_exp(exp_br), perf_exp(exp_mp));
    end
  endtask

  task automatic test_flush_update;
    @(negedge clk);
    flush = 1'b1; upd_en = 1'b1; upd_pc = 32'h0000_5020; upd_taken = 1'b1; upd_mispred = 1'b1;
    @(negedge clk);
    flush = 1'b0; upd_en = 1'b0; upd_mispred = 1'b0; #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL flush_upd_ready: ready=%b, expected 0", ready);
    end
    for (int n = 1; n <= 1024; n++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'(n == 1024)) begin
        errors++; $display("FAIL flush_upd_sweep edge %0d: ready=%b, expected %b", n, ready, n == 1024);
      end
    end
    pc = 32'h0000_5020; #1;
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL flush_upd_dropped: hit=%b, expected 0", hit);
    end
    checks++;
    if (br_cnt !== perf_exp(exp_br) || mp_cnt !== perf_exp(exp_mp)) begin
      errors++; $display("FAIL flush_upd_counted: br=%0d mp=%0d, expected %0d/%0d", br_cnt, mp_cnt, perf_exp(exp_br), perf_exp(exp_mp));
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    upd(32'h0000_1000, 1'b1, 1'b1);
    pc = 32'h0000_1000; #1;
    checks++;
    if (hit !== 1'b1 || br_cnt !== perf_exp(exp_br) || mp_cnt !== perf_exp(exp_mp)) begin
      errors++; $display("FAIL pre_reset: hit=%b br=%0d mp=%0d, expected 1/%0d/%0d", hit, br_cnt, mp_cnt, perf_exp(exp_br), perf_exp(exp_mp));
    end
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++;
    if (ready !== 1'b0 || hit !== 1'b0 || br_cnt !== 32'd0 || mp_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset: ready=%b hit=%b br=%0d mp=%0d, expected 0/0/0/0", ready, hit, br_cnt, mp_cnt);
    end
    exp_br = 0; exp_mp = 0;
    @(negedge clk); rst_n = 1'b1;
    cyc = 0;
    while (ready !== 1'b1 && cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 1024) begin
      errors++; $display("FAIL reinit_latency: ready after %0d edges, expected 1024", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_perf();
    test_allocation();
    test_saturation();
    test_aliasing();
    test_back_to_back();
    test_same_cycle();
    test_flush_mid_sweep();
    test_flush_update();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
